// File: rtl/oled_pkg.sv
// Shared constants, state encodings and the SSD1306 power-up command list
// for the OLED frame scanner.
package oled_pkg;

  localparam int PAGES    = 8;
  localparam int COLUMNS  = 128;
  localparam int INIT_LEN = 25;
  localparam int IDX_W    = 5;

  localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  typedef enum logic [2:0] {
    ST_RES_LOW,
    ST_RES_WAIT,
    ST_INIT,
    ST_FETCH,
    ST_WAIT_ACK,
    ST_SHIFT
  } scan_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_GAP
  } tx_state_e;

  // Out-of-range indices return 0 so the lookup never reads past the table.
  function automatic logic [7:0] init_cmd(input logic [IDX_W-1:0] idx);
    if (idx < IDX_W'(INIT_LEN))
      return INIT_CMDS[idx];
    return 8'h00;
  endfunction

endpackage

// File: rtl/oled_frame_scanner_spi_byte_tx.sv
// Mode-0 SPI byte shifter: CLK_DIV cycles per SCLK half-period, MSB first,
// followed by a CLK_DIV-cycle deselect gap before it accepts the next byte.
module spi_byte_tx
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic       pin_din,
  output logic       pin_clk,
  output logic       pin_cs
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  tx_state_e        st;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       half_cnt;
  logic [7:0]       shreg;
  logic             div_last;

  assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
  // Drops one cycle early so the parent's next load lands right after the gap.
  assign busy = (st == TX_SHIFT) || ((st == TX_GAP) && !div_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= TX_IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      pin_clk  <= 1'b0;
      pin_cs   <= 1'b1;
      pin_din  <= 1'b0;
    end else begin
      case (st)
        TX_IDLE: begin
          if (start) begin
            st       <= TX_SHIFT;
            pin_cs   <= 1'b0;
            pin_clk  <= 1'b0;
            pin_din  <= tx_byte[7];
            div_cnt  <= '0;
            half_cnt <= '0;
          end
        end
        TX_SHIFT: begin
          if (div_last) begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + 1'b1;
            if (!half_cnt[0]) begin
              pin_clk <= 1'b1;
            end else begin
              pin_clk <= 1'b0;
              if (half_cnt == 4'd15) begin
                pin_cs <= 1'b1;
                st     <= TX_GAP;
              end else begin
                pin_din <= shreg[7];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        TX_GAP: begin
          if (div_last) begin
            div_cnt <= '0;
            st      <= TX_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: st <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((st == TX_IDLE) && start)
      shreg <= {tx_byte[6:0], 1'b0};
    else if ((st == TX_SHIFT) && div_last && half_cnt[0])
      shreg <= {shreg[6:0], 1'b0};
  end

endmodule

// File: rtl/oled_frame_scanner.sv
// SSD1306 panel driver: reset pulse, init command stream, then an endless
// horizontal-addressing frame sweep fetching each byte over a read/ack handshake.
module oled_frame_scanner
  import oled_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int RESET_CYCLES = 1200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       ack,
  output logic       pin_din,
  output logic       pin_clk,
  output logic       pin_cs,
  output logic       pin_dc,
  output logic       pin_res,
  output logic       read,
  output logic [2:0] page_idx,
  output logic [6:0] column_idx
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  scan_state_e      state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             cnt_last;
  logic             tx_start;
  logic [7:0]       tx_byte;
  logic             tx_busy;

  assign cnt_last = (cnt == CNT_W'(RESET_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_RES_LOW;
    else
      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    read     = 1'b0;
    tx_start = 1'b0;
    tx_byte  = init_cmd(idx);
    case (state)
      ST_RES_LOW:  if (cnt_last) state_n = ST_RES_WAIT;
      ST_RES_WAIT: if (cnt_last) state_n = ST_INIT;
      ST_INIT: begin
        if (idx == IDX_W'(INIT_LEN)) begin
          state_n = ST_FETCH;
        end else begin
          tx_start = 1'b1;
          state_n  = ST_SHIFT;
        end
      end
      ST_FETCH: begin
        read    = 1'b1;
        state_n = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack) begin
          tx_start = 1'b1;
          tx_byte  = data;
          state_n  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!tx_busy)
          state_n = pin_dc ? ST_FETCH : ST_INIT;
      end
      default: state_n = ST_RES_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      pin_res    <= 1'b0;
      pin_dc     <= 1'b0;
      page_idx   <= '0;
      column_idx <= '0;
    end else begin
      case (state)
        ST_RES_LOW: begin
          cnt <= cnt_last ? '0 : cnt + 1'b1;
          if (cnt_last) pin_res <= 1'b1;
        end
        ST_RES_WAIT: begin
          cnt <= cnt_last ? '0 : cnt + 1'b1;
          if (cnt_last) idx <= '0;
        end
        ST_INIT: begin
          pin_dc <= 1'b0;
          if (idx != IDX_W'(INIT_LEN)) idx <= idx + 1'b1;
        end
        ST_WAIT_ACK: if (ack) pin_dc <= 1'b1;
        ST_SHIFT: begin
          // The panel wraps in horizontal mode, so the address just follows it.
          if (!tx_busy && pin_dc) begin
            if (column_idx == 7'(COLUMNS - 1)) begin
              column_idx <= '0;
              page_idx   <= (page_idx == 3'(PAGES - 1)) ? 3'd0 : page_idx + 1'b1;
            end else begin
              column_idx <= column_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  spi_byte_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk     (clk),
    .rst     (reset),
    .start   (tx_start),
    .tx_byte (tx_byte),
    .busy    (tx_busy),
    .pin_din (pin_din),
    .pin_clk (pin_clk),
    .pin_cs  (pin_cs)
  );

endmodule
